// File: rtl/aes_decrypt_iter.sv
// aes_decrypt_iter: iterative AES-128 decryption core.
// One shared round datapath runs the whole cipher in 21 cycles. The key is
// first expanded forward to K10, then stepped back one round key per cycle
// alongside the inverse rounds.
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   synchronous active-low reset
//   in_valid  in   data_in/key valid
//   in_ready  out  core idle and able to accept a block
//   data_in   in   128-bit ciphertext, [127:120] = byte 0
//   key       in   128-bit cipher key (round-0 key), same byte order
//   out_valid out  data_out holds a plaintext
//   out_ready in   downstream accepts the plaintext
//   data_out  out  128-bit plaintext, same byte order
//   busy      out  high whenever the core is not IDLE
//
// Parameter ZERO_OUT_IDLE: 1 clears data_out after each output handshake,
// 0 keeps the last plaintext visible.
// Optional macro AES_DEC_KEY_CACHE_EN: remembers the last key and its K10 so
// that a repeated key skips forward expansion (11-cycle latency).

package aes_dec_pkg;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = 8'h00;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      acc = acc ^ (b[i] ? sh : 8'h00);
      sh  = xtime(sh);
    end
    return acc;
  endfunction

  // Inverse in GF(2^8) computed as x^254, which also maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = x;
    acc = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  function automatic logic [7:0] sbox_affine(input logic [7:0] v);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^
           {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_affine(input logic [7:0] v);
    return {v[6:0], v[7]} ^ {v[4:0], v[7:5]} ^ {v[1:0], v[7:2]} ^ 8'h05;
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    return {gf_mul(8'h0e, a0) ^ gf_mul(8'h0b, a1) ^ gf_mul(8'h0d, a2) ^ gf_mul(8'h09, a3),
            gf_mul(8'h09, a0) ^ gf_mul(8'h0e, a1) ^ gf_mul(8'h0b, a2) ^ gf_mul(8'h0d, a3),
            gf_mul(8'h0d, a0) ^ gf_mul(8'h09, a1) ^ gf_mul(8'h0e, a2) ^ gf_mul(8'h0b, a3),
            gf_mul(8'h0b, a0) ^ gf_mul(8'h0d, a1) ^ gf_mul(8'h09, a2) ^ gf_mul(8'h0e, a3)};
  endfunction

endpackage

module aes_sbox (
  input  logic [7:0] din,
  output logic [7:0] dout
);
  import aes_dec_pkg::*;
  assign dout = sbox_affine(gf_inv(din));
endmodule

module aes_inv_sbox (
  input  logic [7:0] din,
  output logic [7:0] dout
);
  import aes_dec_pkg::*;
  assign dout = gf_inv(inv_affine(din));
endmodule

module aes_decrypt_iter #(
  parameter int ZERO_OUT_IDLE = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] data_in,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] data_out,
  output logic         busy
);
  import aes_dec_pkg::*;

  typedef enum logic [2:0] {S_IDLE, S_KEYEXP, S_INIT, S_ROUND, S_FINAL, S_DONE} state_t;

  state_t       st;
  logic [127:0] blk;
  logic [127:0] rkey;
  logic [3:0]   rc;

  logic [7:0]   rcon;
  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  sb_word;
  logic [31:0]  rot_word;
  logic [31:0]  sub_word;
  logic [31:0]  rcon_word;
  logic [31:0]  n0, n1, n2, n3;
  logic [127:0] key_fwd;
  logic [127:0] key_inv;
  logic [127:0] isr;
  logic [127:0] isb;
  logic [127:0] imc;

`ifdef AES_DEC_KEY_CACHE_EN
  logic [127:0] cache_key;
  logic [127:0] cache_k10;
  logic         cache_vld;
  logic         cache_hit;
  assign cache_hit = cache_vld && (key == cache_key);
`endif

  // Round constant for the round counter value.
  always_comb begin
    case (rc)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  assign w0 = rkey[127:96];
  assign w1 = rkey[95:64];
  assign w2 = rkey[63:32];
  assign w3 = rkey[31:0];

  // Forward expansion substitutes w3; the inverse step substitutes the
  // recovered previous w3, which is w3^w2. One S-box set serves both.
  assign sb_word   = (st == S_KEYEXP) ? w3 : (w3 ^ w2);
  assign rot_word  = {sb_word[23:0], sb_word[31:24]};
  assign rcon_word = {rcon, 24'h000000};

  for (genvar g = 0; g < 4; g++) begin : g_key_sbox
    aes_sbox u_sbox (.din(rot_word[31-8*g -: 8]), .dout(sub_word[31-8*g -: 8]));
  end

  assign n0      = w0 ^ sub_word ^ rcon_word;
  assign n1      = w1 ^ n0;
  assign n2      = w2 ^ n1;
  assign n3      = w3 ^ n2;
  assign key_fwd = {n0, n1, n2, n3};
  assign key_inv = {w0 ^ sub_word ^ rcon_word, w1 ^ w0, w2 ^ w1, w3 ^ w2};

  // InvShiftRows: row r rotates right by r columns.
  always_comb begin
    isr = 128'd0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        isr[127-8*(r+4*c) -: 8] = blk[127-8*(r+4*((c-r+4)%4)) -: 8];
      end
    end
  end

  for (genvar g = 0; g < 16; g++) begin : g_inv_sbox
    aes_inv_sbox u_inv_sbox (.din(isr[127-8*g -: 8]), .dout(isb[127-8*g -: 8]));
  end

  // AddRoundKey followed by InvMixColumns, column by column.
  always_comb begin
    imc = 128'd0;
    for (int c = 0; c < 4; c++) begin
      imc[127-32*c -: 32] = inv_mix_col(isb[127-32*c -: 32] ^ rkey[127-32*c -: 32]);
    end
  end

  // Control FSM plus state/key/output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st        <= S_IDLE;
      blk       <= 128'd0;
      rkey      <= 128'd0;
      rc        <= 4'd0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      data_out  <= 128'd0;
`ifdef AES_DEC_KEY_CACHE_EN
      cache_key <= 128'd0;
      cache_k10 <= 128'd0;
      cache_vld <= 1'b0;
`endif
    end else begin
      case (st)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            blk      <= data_in;
            in_ready <= 1'b0;
            busy     <= 1'b1;
`ifdef AES_DEC_KEY_CACHE_EN
            if (cache_hit) begin
              rkey <= cache_k10;
              rc   <= 4'd10;
              st   <= S_INIT;
            end else begin
              rkey      <= key;
              rc        <= 4'd1;
              st        <= S_KEYEXP;
              cache_key <= key;
              cache_vld <= 1'b0;
            end
`else
            rkey <= key;
            rc   <= 4'd1;
            st   <= S_KEYEXP;
`endif
          end else begin
            in_ready <= 1'b1;
          end
        end
        S_KEYEXP: begin
          rkey <= key_fwd;
          if (rc == 4'd10) begin
            st <= S_INIT;
`ifdef AES_DEC_KEY_CACHE_EN
            cache_k10 <= key_fwd;
            cache_vld <= 1'b1;
`endif
          end else begin
            rc <= rc + 4'd1;
          end
        end
        S_INIT: begin
          blk  <= blk ^ rkey;
          rkey <= key_inv;
          rc   <= 4'd9;
          st   <= S_ROUND;
        end
        S_ROUND: begin
          blk  <= imc;
          rkey <= key_inv;
          if (rc == 4'd1) begin
            st <= S_FINAL;
          end else begin
            rc <= rc - 4'd1;
          end
        end
        S_FINAL: begin
          data_out  <= isb ^ rkey;
          out_valid <= 1'b1;
          st        <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            st        <= S_IDLE;
            if (ZERO_OUT_IDLE != 0) begin
              data_out <= 128'd0;
            end
          end
        end
        default: begin
          st        <= S_IDLE;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_decrypt_iter.sv
module tb_aes_decrypt_iter;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] data_in;
  logic [127:0] key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] data_out;
  logic         busy;

  int total;
  int bad;

  aes_decrypt_iter #(.ZERO_OUT_IDLE(0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .data_in(data_in), .key(key), .out_valid(out_valid), .out_ready(out_ready),
    .data_out(data_out), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model (table/log based AES encrypt) ----------
  logic [7:0]  gexp [256];
  int          glog [256];
  logic [7:0]  sb   [256];
  logic [31:0] w    [44];

`ifdef AES_DEC_KEY_CACHE_EN
  logic [127:0] mc_key;
  logic         mc_vld;
`endif

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    if (a == 8'h00 || b == 8'h00) return 8'h00;
    return gexp[(glog[a] + glog[b]) % 255];
  endfunction

  task automatic build_tables();
    logic [7:0] p;
    logic [7:0] v;
    logic [7:0] o;
    logic [7:0] c;
    p = 8'h01;
    for (int i = 0; i < 255; i++) begin
      gexp[i] = p;
      glog[p] = i;
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
    end
    gexp[255] = 8'h01;
    glog[0]   = 0;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      v = (x == 0) ? 8'h00 : gexp[(255 - glog[x]) % 255];
      for (int b = 0; b < 8; b++)
        o[b] = v[b] ^ v[(b+4)%8] ^ v[(b+5)%8] ^ v[(b+6)%8] ^ v[(b+7)%8] ^ c[b];
      sb[x] = o;
    end
  endtask

  task automatic expand(input logic [127:0] k);
    logic [31:0] t;
    logic [7:0]  rcv;
    rcv = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rcv, 24'h000000};
        rcv = {rcv[6:0], 1'b0} ^ (rcv[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
  endtask

  function automatic logic [7:0] mcoef(input int d);
    case (d)
      0:       return 8'h02;
      1:       return 8'h03;
      default: return 8'h01;
    endcase
  endfunction

  function automatic logic [127:0] encrypt(input logic [127:0] pt);
    logic [127:0] s;
    logic [127:0] u;
    logic [7:0]   acc;
    s = pt ^ {w[0], w[1], w[2], w[3]};
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) u[127-8*i -: 8] = sb[s[127-8*i -: 8]];
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++)
          s[127-8*(rr+4*c) -: 8] = u[127-8*(rr+4*((c+rr)%4)) -: 8];
      if (r != 10) begin
        for (int c = 0; c < 4; c++)
          for (int rr = 0; rr < 4; rr++) begin
            acc = 8'h00;
            for (int k = 0; k < 4; k++)
              acc = acc ^ gmul(mcoef((k - rr + 4) % 4), s[127-8*(4*c+k) -: 8]);
            u[127-8*(4*c+rr) -: 8] = acc;
          end
        s = u;
      end
      s = s ^ {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    end
    return s;
  endfunction

  // Expected latency: 11 on a cached-key hit, 21 otherwise.
  function automatic int exp_lat(input logic [127:0] k);
`ifdef AES_DEC_KEY_CACHE_EN
    if (mc_vld && k == mc_key) return 11;
`endif
    return 21;
  endfunction

  task automatic note_accept(input logic [127:0] k);
`ifdef AES_DEC_KEY_CACHE_EN
    if (!(mc_vld && k == mc_key)) begin
      mc_key = k;
      mc_vld = 1'b1;
    end
`endif
  endtask

  task automatic note_reset();
`ifdef AES_DEC_KEY_CACHE_EN
    mc_vld = 1'b0;
`endif
  endtask

  // ---------------- bench helpers ----------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic accept_block(input logic [127:0] k, input logic [127:0] ct, output int waited);
    waited = 0;
    while (in_ready !== 1'b1 && waited < 200) begin
      step();
      waited++;
    end
    chk("in_ready_before_accept", 128'(in_ready), 128'd1);
    data_in  = ct;
    key      = k;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    data_in  = {$urandom(), $urandom(), $urandom(), $urandom()};
    key      = {$urandom(), $urandom(), $urandom(), $urandom()};
    chk("busy_after_accept", 128'(busy), 128'd1);
    chk("in_ready_after_accept", 128'(in_ready), 128'd0);
  endtask

  task automatic wait_result(input logic [127:0] pt, input int elat, input string nm);
    int n;
    n = 0;
    while (out_valid !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    chk({nm, "_latency"}, 128'(n), 128'(elat));
    chk({nm, "_data"}, data_out, pt);
    chk({nm, "_in_ready_done"}, 128'(in_ready), 128'd0);
    chk({nm, "_busy_done"}, 128'(busy), 128'd1);
  endtask

  task automatic handshake(input logic [127:0] pt);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("out_valid_after_hs", 128'(out_valid), 128'd0);
    chk("in_ready_after_hs", 128'(in_ready), 128'd1);
    chk("busy_after_hs", 128'(busy), 128'd0);
    chk("data_out_hold_after_hs", data_out, pt);
  endtask

  task automatic run_block(input logic [127:0] k, input logic [127:0] ct,
                           input logic [127:0] pt, input string nm);
    int lat;
    int wt;
    lat = exp_lat(k);
    note_accept(k);
    accept_block(k, ct, wt);
    wait_result(pt, lat, nm);
    handshake(pt);
  endtask

  typedef struct {
    logic [127:0] key;
    logic [127:0] ct;
    logic [127:0] pt;
  } vec_t;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

  initial begin
    vec_t         vt [5];
    logic [127:0] rk;
    logic [127:0] rp;
    int           lat;
    int           wt;
    int           seen;

    total = 0;
    bad   = 0;
    build_tables();
    note_reset();

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    data_in   = 128'd0;
    key       = 128'd0;
    repeat (3) step();
    chk("reset_in_ready", 128'(in_ready), 128'd0);
    chk("reset_out_valid", 128'(out_valid), 128'd0);
    chk("reset_busy", 128'(busy), 128'd0);
    chk("reset_data_out", data_out, 128'd0);
    rst_n = 1'b1;
    step();
    chk("idle_in_ready", 128'(in_ready), 128'd1);
    chk("idle_busy", 128'(busy), 128'd0);

    // Directed table: FIPS vectors, a repeated key and a model-encrypted block.
    vt[0] = '{C1_KEY, C1_CT, C1_PT};
    vt[1] = '{B_KEY, B_CT, B_PT};
    vt[2] = '{B_KEY, B_CT, B_PT};
    rk = {$urandom(), $urandom(), $urandom(), $urandom()};
    rp = {$urandom(), $urandom(), $urandom(), $urandom()};
    expand(rk);
    vt[3] = '{rk, encrypt(rp), rp};
    vt[4] = '{C1_KEY, C1_CT, C1_PT};
    for (int i = 0; i < 5; i++) run_block(vt[i].key, vt[i].ct, vt[i].pt, "table");

    // Backpressure: DONE holds for 50 cycles, in_valid pulses ignored.
    lat = exp_lat(B_KEY);
    note_accept(B_KEY);
    accept_block(B_KEY, B_CT, wt);
    wait_result(B_PT, lat, "bp");
    for (int i = 0; i < 50; i++) begin
      in_valid = (i % 3 == 0);
      data_in  = {$urandom(), $urandom(), $urandom(), $urandom()};
      key      = {$urandom(), $urandom(), $urandom(), $urandom()};
      step();
      chk("bp_out_valid", 128'(out_valid), 128'd1);
      chk("bp_data_stable", data_out, B_PT);
      chk("bp_in_ready", 128'(in_ready), 128'd0);
    end
    in_valid = 1'b0;
    handshake(B_PT);
    lat = exp_lat(C1_KEY);
    note_accept(C1_KEY);
    accept_block(C1_KEY, C1_CT, wt);
    chk("bp_reaccept_wait", 128'(wt), 128'd0);
    wait_result(C1_PT, lat, "bp_next");
    handshake(C1_PT);

    // Reset during the 7th ROUND cycle discards the block.
    lat = exp_lat(C1_KEY);
    note_accept(C1_KEY);
    accept_block(C1_KEY, C1_CT, wt);
    repeat (lat - 10 + 6) step();
    chk("pre_reset_busy", 128'(busy), 128'd1);
    chk("pre_reset_out_valid", 128'(out_valid), 128'd0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    note_reset();
    chk("midrst_out_valid", 128'(out_valid), 128'd0);
    chk("midrst_busy", 128'(busy), 128'd0);
    chk("midrst_data_out", data_out, 128'd0);
    chk("midrst_in_ready", 128'(in_ready), 128'd0);
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      step();
      if (out_valid === 1'b1) seen++;
    end
    chk("midrst_no_stale_output", 128'(seen), 128'd0);
    run_block(C1_KEY, C1_CT, C1_PT, "after_reset");

    // Random blocks encrypted by the model; every 4th reuses the previous key.
    for (int i = 0; i < 1000; i++) begin
      if (i % 4 != 3) rk = {$urandom(), $urandom(), $urandom(), $urandom()};
      rp = {$urandom(), $urandom(), $urandom(), $urandom()};
      expand(rk);
      run_block(rk, encrypt(rp), rp, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
